// File: rtl/pc_fetch_unit_pkg.sv
// Shared core package: PC/target widths, reset PC, increment,
// next-pc select encoding (also used by the hazard controller), IF/ID bundle.
package pc_fetch_unit_pkg;

    localparam int PC_W   = 10;
    localparam int DATA_W = 32;

    localparam logic [PC_W-1:0] RESET_PC = 10'h000;
    localparam logic [PC_W-1:0] PC_INC   = 10'd4;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_HOLD = 2'd1,
        SEL_BR   = 2'd2,
        SEL_JALR = 2'd3
    } pc_sel_e;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pc4;
    } if_id_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-pc mux: sel, pc, br_target, jalr_target in;
// word-aligned next_pc and misalign (target had nonzero low bits) out.
module pc_next_sel
    import pc_fetch_unit_pkg::*;
(
    input  logic [1:0]      sel,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] jalr_target,
    output logic [PC_W-1:0] next_pc,
    output logic            misalign
);

    logic [PC_W-1:0] tgt;

    always_comb begin
        tgt      = br_target;
        next_pc  = pc + PC_INC;
        misalign = 1'b0;
        case (sel)
            SEL_JALR: begin
                // JALR clears bit0 first; only bit1 can then flag
                tgt      = {jalr_target[PC_W-1:1], 1'b0};
                next_pc  = {tgt[PC_W-1:2], 2'b00};
                misalign = |tgt[1:0];
            end
            SEL_BR: begin
                tgt      = br_target;
                next_pc  = {tgt[PC_W-1:2], 2'b00};
                misalign = |tgt[1:0];
            end
            SEL_HOLD: next_pc = pc;
            default:  next_pc = pc + PC_INC;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and IF/ID PC register. Inputs: clk, rst, stall,
// br_taken/pc_imm, jalr_en/jalr_target. Outputs: pc, pc_d, pc4_d, valid_d, misalign.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [DATA_W-1:0] pc_imm,
    input  logic              jalr_en,
    input  logic [DATA_W-1:0] jalr_target,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_d,
    output logic [PC_W-1:0]   pc4_d,
    output logic              valid_d,
    output logic              misalign
);

    pc_sel_e         sel;
    logic            redirect;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] next_pc;
    logic            mis_next;
    logic            mis_q;
    if_id_t          if_id_q;

    // Upper target bits fall outside instruction memory; dropped silently
    logic unused_bits;
    assign unused_bits = ^{pc_imm[DATA_W-1:PC_W],
                           jalr_target[DATA_W-1:PC_W]};

    assign redirect = jalr_en | br_taken;

    // Redirect beats stall: the redirecting instruction is in execute
    always_comb begin
        if (jalr_en)       sel = SEL_JALR;
        else if (br_taken) sel = SEL_BR;
        else if (stall)    sel = SEL_HOLD;
        else               sel = SEL_SEQ;
    end

    pc_next_sel u_next_sel (
        .sel         (sel),
        .pc          (pc_q),
        .br_target   (pc_imm[PC_W-1:0]),
        .jalr_target (jalr_target[PC_W-1:0]),
        .next_pc     (next_pc),
        .misalign    (mis_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            if_id_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            pc_q  <= next_pc;
            mis_q <= mis_next;
            if (redirect) begin
                if_id_q <= '0;
            end else if (!stall) begin
                if_id_q.valid <= 1'b1;
                if_id_q.pc    <= pc_q;
                if_id_q.pc4   <= pc_q + PC_INC;
            end
        end
    end

    assign pc       = pc_q;
    assign pc_d     = if_id_q.pc;
    assign pc4_d    = if_id_q.pc4;
    assign valid_d  = if_id_q.valid;
    assign misalign = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed plan plus random traffic,
// expectations from an arithmetic reference model queued per cycle.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] pc_imm;
    logic        jalr_en;
    logic [31:0] jalr_target;
    logic [9:0]  pc;
    logic [9:0]  pc_d;
    logic [9:0]  pc4_d;
    logic        valid_d;
    logic        misalign;

    pc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_taken    (br_taken),
        .pc_imm      (pc_imm),
        .jalr_en     (jalr_en),
        .jalr_target (jalr_target),
        .pc          (pc),
        .pc_d        (pc_d),
        .pc4_d       (pc4_d),
        .valid_d     (valid_d),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned pc;
        int unsigned pc_d;
        int unsigned pc4_d;
        int unsigned valid_d;
        int unsigned misalign;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference state
    int unsigned m_pc = 0;
    int unsigned m_pcd = 0;
    int unsigned m_pc4d = 0;
    int unsigned m_valid = 0;
    int unsigned m_mis = 0;

    task automatic model_step(input bit r, input bit s, input bit b,
                              input int unsigned imm, input bit j,
                              input int unsigned jt);
        int unsigned t;
        if (r) begin
            m_pc = 0; m_pcd = 0; m_pc4d = 0; m_valid = 0; m_mis = 0;
        end else if (j || b) begin
            if (j) t = (jt % 1024) - (jt % 2);
            else   t = imm % 1024;
            m_mis   = (t % 4 != 0) ? 1 : 0;
            m_pc    = t - (t % 4);
            m_pcd   = 0;
            m_pc4d  = 0;
            m_valid = 0;
        end else if (s) begin
            m_mis = 0;
        end else begin
            m_pcd   = m_pc;
            m_pc4d  = (m_pc + 4) % 1024;
            m_valid = 1;
            m_pc    = (m_pc + 4) % 1024;
            m_mis   = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit b,
                       input int unsigned imm, input bit j,
                       input int unsigned jt);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; br_taken = b; pc_imm = imm;
        jalr_en = j; jalr_target = jt;
        model_step(r, s, b, imm, j, jt);
        e.pc = m_pc; e.pc_d = m_pcd; e.pc4_d = m_pc4d;
        e.valid_d = m_valid; e.misalign = m_mis;
        q.push_back(e);
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int unsigned act,
                       input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // monitor: one expected entry per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", 32'(pc), e.pc);
                chk("pc_d", 32'(pc_d), e.pc_d);
                chk("pc4_d", 32'(pc4_d), e.pc4_d);
                chk("valid_d", 32'(valid_d), e.valid_d);
                chk("misalign", 32'(misalign), e.misalign);
            end
        end
    end

    initial begin
        int unsigned r_imm;
        int unsigned r_jt;
        bit r_r, r_s, r_b, r_j;
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0;
        pc_imm = '0; jalr_en = 1'b0; jalr_target = '0;

        // reset, then sequential fetch
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        free_run(5);
        // misaligned branch while pc_d=0x010
        cyc(0, 0, 1, 32'h0000_0013, 0, 0);
        free_run(2);
        // stall hold, then redirect overriding stall
        cyc(0, 0, 1, 32'h0000_0020, 0, 0);
        free_run(1);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 32'h0000_0040, 0, 0);
        free_run(2);
        // JALR beats branch, bit0 cleared silently
        cyc(0, 0, 1, 32'h0000_0080, 1, 32'h0000_0105);
        free_run(2);
        // wrap at top of memory
        cyc(0, 0, 1, 32'h0000_03F8, 0, 0);
        free_run(4);
        // upper target bits dropped
        cyc(0, 0, 1, 32'hFFFF_F0A8, 0, 0);
        free_run(2);
        // misaligned redirect, then reset during stalled redirect
        cyc(0, 0, 1, 32'h0000_0102, 0, 0);
        cyc(1, 1, 1, 32'h0000_0013, 1, 32'h0000_0007);
        free_run(3);

        for (int i = 0; i < 400; i++) begin
            r_r   = ($urandom_range(0, 99) < 2);
            r_s   = ($urandom_range(0, 99) < 25);
            r_b   = ($urandom_range(0, 99) < 10);
            r_j   = ($urandom_range(0, 99) < 5);
            r_imm = $urandom;
            r_jt  = $urandom;
            cyc(r_r, r_s, r_b, r_imm, r_j, r_jt);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and the IF/ID PC pipeline register for the single-issue RISC-V core.
- Produces pc_d, the decode-stage PC, which add_imm adds to the immediate.
- Consumes add_imm's pc_imm result as the branch/JAL redirect target.
- Also takes a JALR target from the ALU, and handles stall and redirect-flush of the decode slot.

Parameters:
PC_W, 10, width of instruction address (word-aligned byte address into 1 KiB instruction memory)
DATA_W, 32, width of target buses from add_imm / ALU
RESET_PC, 10'h000, PC value loaded on reset

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hazard stall: hold pc and decode register
br_taken  input  1  branch/JAL taken this cycle; redirect to pc_imm
pc_imm  input  DATA_W  target from add_imm (pc_d + imm)
jalr_en  input  1  JALR taken this cycle; redirect to jalr_target
jalr_target  input  DATA_W  rs1+imm from ALU
pc  output  PC_W  fetch address to instruction memory
pc_d  output  PC_W  PC of instruction in decode stage (to add_imm)
pc4_d  output  PC_W  pc_d+4 (link value for JAL/JALR)
valid_d  output  1  decode slot holds a real instruction
misalign  output  1  one-cycle pulse: redirect target had nonzero bits [1:0]

Behaviour:
- Reset (rst=1 at a rising edge) sets:
  - pc=RESET_PC; pc_d=0; pc4_d=0; valid_d=0; misalign=0.
  - rst has priority over every other input.
- Next-pc selection, priority high→low:
  - rst.
  - jalr_en: target = jalr_target[PC_W-1:0] with bit0 forced to 0.
  - br_taken: target = pc_imm[PC_W-1:0].
  - stall: pc holds.
  - Otherwise pc = pc+4.
- A redirect (jalr_en or br_taken) overrides stall. The redirecting instruction is in execute and must not be held.
- Redirect target alignment:
  - Bits [1:0] of the selected target are cleared before loading pc.
  - misalign=1 for exactly the cycle after a redirect whose target, after the JALR bit0 clear, had bit1 or bit0 set.
  - misalign=0 in all other cycles.
- Upper target bits [DATA_W-1:PC_W] are ignored: truncation, no error.
- Increment is modulo 2^PC_W: pc=0x3FC → 0x000, no flag.
- Decode register update, same priority as pc:
  - Redirect: valid_d←0, pc_d←0, pc4_d←0 (flush the wrong-path instruction, one bubble).
  - Else stall: pc_d, pc4_d, valid_d hold.
  - Else: pc_d←pc, pc4_d←pc+4 (mod 2^PC_W), valid_d←1.
- Latency:
  - The redirect target appears on pc the cycle after br_taken/jalr_en.
  - The target instruction reaches pc_d one cycle later: 2-cycle taken-branch penalty.
- First cycle after reset release: pc=RESET_PC, valid_d=0. One cycle later pc_d=RESET_PC, valid_d=1.
- Simultaneous jalr_en and br_taken: JALR wins (controller error case; deterministic only).
- Reset asserted mid-stall or mid-redirect: reset state next cycle, no residual misalign.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared core package holds:
  - PC_W, DATA_W, RESET_PC.
  - The constant PC_INC=4.
  - An enum for the next-pc select (SEL_SEQ, SEL_HOLD, SEL_BR, SEL_JALR), also used by the hazard controller.
- One natural sub-module: pc_next_sel. It is combinational: it takes the select, pc and the two targets, and returns the aligned next pc and the misalign bit.
- The top level holds the pc and IF/ID registers.

Test Plan:
- Reset then 4 free cycles → pc 0x000,0x004,0x008,0x00C; pc_d lags by one cycle; valid_d rises the cycle after reset release.
- pc_d=0x010, pc_imm=0x00000013 → pc_imm is misaligned (bits[1:0]=11). With br_taken=1 → next pc=0x010, misalign pulse, valid_d=0 one cycle, then pc_d=0x010.
- stall=1 for 3 cycles at pc=0x020 → pc, pc_d, valid_d frozen. Then stall with br_taken=1, pc_imm=0x00000040 → pc=0x040 next cycle, stall ignored.
- jalr_en=1, jalr_target=0x00000105, br_taken=1, pc_imm=0x080 → pc=0x104 (JALR wins), misalign=0, valid_d=0.
- Run to pc=0x3FC → next pc=0x000, pc4_d for pc_d=0x3FC equals 0x000. Redirect with pc_imm=0xFFFFF0A8 → pc=0x0A8.
- Assert rst during a redirect cycle with stall=1 → next cycle pc=0x000, pc_d=0, valid_d=0, misalign=0.
